cordic_divider_approx_2tn_iter: RTL

//  Linear-vectoring CORDIC divider, the inverse of the linear-rotation CORDIC multiplier.

---
 rtl/cordic_divider_approx_2tn_iter_pkg.sv | 47 ++++
 rtl/cordic_divider_approx_2tn_iter_add16se_2tn.sv | 39 +++
 rtl/cordic_divider_approx_2tn_iter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cordic_divider_approx_2tn_iter_pkg.sv
// -----------------------------------------------------------------------------
// cordic_divider_approx_2tn_iter_pkg
//   Shared definitions for the linear CORDIC arithmetic blocks (divider and
//   the matching multiplier): working-register format, default iteration
//   count and output scale, FSM state encoding, and small helper functions.
//
//   Contents:
//     FRAC_BITS       fractional bits of the 16-bit working registers
//     WORK_W          width of the working registers
//     DEF_ITERATIONS  default number of micro-rotations
//     DEF_SCALE       default output quotient scale (Q1.7)
//     state_t         IDLE / RUN / FIN
//     z_update()      angle-accumulator step for a given shift amount
//     saturate8()     clamp a wide signed value to the signed 8-bit range
// -----------------------------------------------------------------------------
package cordic_divider_approx_2tn_iter_pkg;

  localparam int FRAC_BITS      = 8;
  localparam int WORK_W         = 16;
  localparam int DEF_ITERATIONS = 9;
  localparam int DEF_SCALE      = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // 1.0 in the working format, shifted right by the iteration's shift amount.
  // Once the shift exceeds FRAC_BITS the step is zero.
  function automatic logic signed [WORK_W-1:0] z_update(input logic [4:0] shamt);
    return 16'sh0100 >>> shamt;
  endfunction

  function automatic logic signed [7:0] saturate8(input logic signed [31:0] v);
    logic signed [7:0] res;
    if (v > 32'sd127) begin
      res = 8'sh7f;
    end else if (v < -32'sd128) begin
      res = 8'sh80;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_divider_approx_2tn_iter_add16se_2tn.sv
// -----------------------------------------------------------------------------
// add16se_2TN
//   Approximate sign-extended 16-bit adder. The two least significant bits
//   are formed with a carry-free OR; the carry into bit 2 is predicted from
//   the top approximate bit pair (A[1] & B[1]). The upper 14 bits are an
//   exact sign-extended add, giving a 17-bit result.
//
//   The result is exact whenever the operands have no common set bit in
//   positions [1:0].
//
//   Ports:
//     i_a    in  16  signed operand A
//     i_b    in  16  signed operand B
//     o_sum  out 17  approximate A + B, sign-extended
// -----------------------------------------------------------------------------
module add16se_2TN
  import cordic_divider_approx_2tn_iter_pkg::*;
(
  input  logic [WORK_W-1:0] i_a,
  input  logic [WORK_W-1:0] i_b,
  output logic [WORK_W:0]   o_sum
);

  logic [1:0]        w_lo;
  logic              w_carry;
  logic [WORK_W-2:0] w_hi;

  assign w_lo    = i_a[1:0] | i_b[1:0];
  assign w_carry = i_a[1] & i_b[1];

  // Upper part: bits [15:2] of each operand, sign-extended by one bit so the
  // 15-bit sum carries the true sign into o_sum[16].
  assign w_hi = {i_a[WORK_W-1], i_a[WORK_W-1:2]}
              + {i_b[WORK_W-1], i_b[WORK_W-1:2]}
              + {{(WORK_W-2){1'b0}}, w_carry};

  assign o_sum = {w_hi, w_lo};

endmodule

// File: rtl/cordic_divider_approx_2tn_iter.sv
// -----------------------------------------------------------------------------
// cordic_divider_approx_2tn_iter
//   Iterative linear-vectoring CORDIC divider: q ~= SCALE*y/x as a signed
//   Q1.7 value, one micro-rotation per clock. The y residual is updated
//   through the approximate add16se_2TN adder, the z accumulator is exact.
//
//   Ports:
//     i_clk    in   1  rising-edge clock
//     i_rst_n  in   1  asynchronous active-low reset
//     i_start  in   1  request, sampled only in IDLE
//     i_y      in   8  signed dividend
//     i_x      in   8  signed divisor
//     o_q      out  8  signed quotient, held until the next result
//     o_busy   out  1  high while iterating
//     o_done   out  1  one-cycle pulse when o_q / o_err are valid
//     o_err    out  1  divide-by-zero flag, valid with o_done, held
// -----------------------------------------------------------------------------
module cordic_divider_approx_2tn_iter
  import cordic_divider_approx_2tn_iter_pkg::*;
#(
  parameter int ITERATIONS = DEF_ITERATIONS,
  parameter int SCALE      = DEF_SCALE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic signed [7:0] i_y,
  input  logic signed [7:0] i_x,
  output logic signed [7:0] o_q,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int              IT_W    = $clog2(ITERATIONS + 1);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(ITERATIONS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [7:0]        r_x;
  logic signed [WORK_W-1:0] r_yw;
  logic signed [WORK_W-1:0] r_zw;
  logic [IT_W-1:0]          r_it;
  logic                     r_err_pend;
  logic signed [7:0]        r_q;
  logic                     r_done;
  logic                     r_err;

  logic [4:0]               w_shamt;
  logic signed [WORK_W-1:0] w_xs;
  logic signed [WORK_W-1:0] w_zu;
  logic signed [WORK_W-1:0] w_b;
  logic                     w_d_pos;
  logic [WORK_W:0]          w_sum;
  logic                     w_unused;
  logic signed [31:0]       w_prod;
  logic signed [31:0]       w_scaled;

  // Iteration i uses shift i+1, derived directly from the counter.
  assign w_shamt = 5'(r_it) + 5'd1;
  assign w_xs    = $signed({r_x, {FRAC_BITS{1'b0}}}) >>> w_shamt;
  assign w_zu    = z_update(w_shamt);

  // Drive the residual toward zero: same sign as x means subtract. A zero
  // residual has a clear sign bit and so counts as non-negative.
  assign w_d_pos = (r_yw[WORK_W-1] == r_x[7]);
  assign w_b     = w_d_pos ? -w_xs : w_xs;

  add16se_2TN u_add (
    .i_a   (r_yw),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // The residual never needs the extension bit; it stays within 16 bits.
  assign w_unused = w_sum[WORK_W];

  assign w_prod   = 32'(r_zw) * SCALE;
  assign w_scaled = w_prod >>> FRAC_BITS;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (i_x == 8'sd0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_it == LAST_IT) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand capture, micro-rotations and result registration. The result
  // registers only change in FIN, so o_q / o_err hold between divisions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_yw       <= '0;
      r_zw       <= '0;
      r_it       <= '0;
      r_err_pend <= 1'b0;
      r_q        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_x        <= i_x;
            r_yw       <= (i_x == 8'sd0) ? '0 : $signed({i_y, {FRAC_BITS{1'b0}}});
            r_zw       <= '0;
            r_it       <= '0;
            r_err_pend <= (i_x == 8'sd0);
          end
        end
        ST_RUN: begin
          r_yw <= w_sum[WORK_W-1:0];
          r_zw <= w_d_pos ? (r_zw + w_zu) : (r_zw - w_zu);
          r_it <= r_it + 1'b1;
        end
        ST_FIN: begin
          r_done <= 1'b1;
          r_err  <= r_err_pend;
          r_q    <= r_err_pend ? 8'sd0 : saturate8(w_scaled);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_q    = r_q;

endmodule
